// File: rtl/audio_pwm_dac_pkg.sv
// Shared audio-path definitions: gain FSM states, gain range, midscale and LFSR constants.
package audio_pwm_dac_pkg;

    typedef enum logic [1:0] {
        ST_MUTE,
        ST_UP,
        ST_RUN,
        ST_DOWN
    } gain_state_t;

    typedef logic [8:0] gain_t;

    localparam gain_t       GAIN_MAX            = 9'd256;
    localparam int          AUDIO_CODE_MIDSCALE = 8192;
    localparam logic [15:0] LFSR_SEED           = 16'hACE1;
    // Fibonacci taps 16,14,13,11 expressed as a bit mask over the state
    localparam logic [15:0] LFSR_TAPS           = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/audio_gain_ramp.sv
// Mute/unmute gain ramp: steps the 0..256 gain by one per PWM period on the wrap tick.
module audio_gain_ramp
    import audio_pwm_dac_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       wrap,
    output logic [8:0] gain,
    output logic       active
);

    gain_state_t r_state;
    gain_state_t w_state_nxt;
    gain_t       r_gain;
    gain_t       w_gain_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_MUTE;
            r_gain  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gain  <= w_gain_nxt;
        end
    end

    // Reaching a ramp endpoint takes priority over a direction change at the same wrap
    always_comb begin
        w_state_nxt = r_state;
        w_gain_nxt  = r_gain;
        if (wrap) begin
            unique case (r_state)
                ST_MUTE: begin
                    w_gain_nxt = '0;
                    if (enable) w_state_nxt = ST_UP;
                end
                ST_UP: begin
                    if (r_gain >= GAIN_MAX - 9'd1) begin
                        w_gain_nxt  = GAIN_MAX;
                        w_state_nxt = ST_RUN;
                    end else if (!enable) begin
                        w_state_nxt = ST_DOWN;
                    end else begin
                        w_gain_nxt = r_gain + 9'd1;
                    end
                end
                ST_RUN: begin
                    w_gain_nxt = GAIN_MAX;
                    if (!enable) w_state_nxt = ST_DOWN;
                end
                ST_DOWN: begin
                    if (r_gain <= 9'd1) begin
                        w_gain_nxt  = '0;
                        w_state_nxt = ST_MUTE;
                    end else if (enable) begin
                        w_state_nxt = ST_UP;
                    end else begin
                        w_gain_nxt = r_gain - 9'd1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        active = (r_state != ST_MUTE);
        gain   = r_gain;
    end

endmodule

// File: rtl/audio_pwm_dac.sv
// Audio PWM DAC: period counter, gain-scaled sample pipeline and PWM comparator.
// Define AUDIO_PWM_DITHER_EN to add LFSR dither ahead of duty truncation.
module audio_pwm_dac
    import audio_pwm_dac_pkg::*;
#(
    parameter int unsigned CODE_WIDTH   = 14,
    parameter int unsigned PERIOD_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [CODE_WIDTH-1:0] code,
    output logic                  next_sample,
    output logic                  pwm_out,
    output logic                  active
);

    localparam int unsigned             S1W      = CODE_WIDTH + 10;
    localparam logic [PERIOD_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [PERIOD_WIDTH-1:0] CNT_NS   = CNT_MAX - PERIOD_WIDTH'(3);
    localparam logic [PERIOD_WIDTH-1:0] CNT_MUL  = CNT_MAX - PERIOD_WIDTH'(2);
    localparam logic [PERIOD_WIDTH-1:0] CNT_ADD  = CNT_MAX - PERIOD_WIDTH'(1);
    localparam logic [CODE_WIDTH-1:0]   MID      = {1'b1, {(CODE_WIDTH-1){1'b0}}};
    localparam logic [PERIOD_WIDTH-1:0] DUTY_RST = MID[CODE_WIDTH-1 -: PERIOD_WIDTH];

    logic [PERIOD_WIDTH-1:0]  r_cnt;
    logic [PERIOD_WIDTH-1:0]  r_duty;
    logic [PERIOD_WIDTH-1:0]  w_duty_next;
    logic signed [S1W-1:0]    r_s1;
    logic signed [S1W-1:0]    w_prod;
    logic signed [S1W-1:0]    w_s1_shr;
    logic signed [S1W-1:0]    w_s2_sum;
    logic [CODE_WIDTH-1:0]    r_s2;
    logic [CODE_WIDTH-1:0]    w_s2_q;
    logic signed [CODE_WIDTH:0] w_diff;
    logic [8:0]               w_gain;
    logic                     r_pwm;
    logic                     w_wrap;
    logic                     w_unused;

    assign w_wrap      = (r_cnt == CNT_MAX);
    assign next_sample = (r_cnt == CNT_NS);
    assign pwm_out     = r_pwm;

    // Offset-binary to signed, then 24-bit signed product; the true result always fits
    assign w_diff   = $signed({1'b0, code}) - $signed({1'b0, MID});
    assign w_prod   = $signed({{9{w_diff[CODE_WIDTH]}}, w_diff})
                    * $signed({{(CODE_WIDTH+1){1'b0}}, w_gain});
    assign w_s1_shr = r_s1 >>> 8;
    assign w_s2_sum = $signed({10'b0, MID}) + w_s1_shr;

`ifdef AUDIO_PWM_DITHER_EN
    localparam int unsigned SHIFT = CODE_WIDTH - PERIOD_WIDTH;

    logic [15:0]         r_lfsr;
    logic [CODE_WIDTH:0] w_dsum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lfsr <= LFSR_SEED;
        end else if (w_wrap) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign w_dsum = {1'b0, r_s2} + {{(PERIOD_WIDTH+1){1'b0}}, r_lfsr[SHIFT-1:0]};
    assign w_s2_q = w_dsum[CODE_WIDTH] ? '1 : w_dsum[CODE_WIDTH-1:0];
`else
    assign w_s2_q = r_s2;
`endif

    assign w_duty_next = w_s2_q[CODE_WIDTH-1 -: PERIOD_WIDTH];
    assign w_unused    = ^{w_s2_sum[S1W-1:CODE_WIDTH], w_s2_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_s1   <= '0;
            r_s2   <= MID;
            r_duty <= DUTY_RST;
            r_pwm  <= 1'b0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            r_pwm <= (r_cnt < r_duty);
            if (r_cnt == CNT_MUL) r_s1   <= w_prod;
            if (r_cnt == CNT_ADD) r_s2   <= w_s2_sum[CODE_WIDTH-1:0];
            if (w_wrap)           r_duty <= w_duty_next;
        end
    end

    audio_gain_ramp u_gain_ramp (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .wrap   (w_wrap),
        .gain   (w_gain),
        .active (active)
    );

endmodule
